// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the EX stage: widths, ALU opcodes, CCR bit
// positions and the EX/MEM buffer layout.
package pipeline_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MOV   = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_NOT   = 4'd6,
    OP_INC   = 4'd7,
    OP_DEC   = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_SETC  = 4'd11,
    OP_CLRC  = 4'd12,
    OP_MUL   = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_t;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] Rsrc_value;
    logic [DATA_W-1:0] Rdst_value;
    logic [REG_AW-1:0] Rdst_address;
    logic              memRead;
    logic              memWrite;
    logic              WB;
  } ex_mem_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, hazard controls, MEM/WB snoop and EX/MEM outputs of the EX stage.
interface execute_stage_if import pipeline_pkg::*; ();

  logic              id_valid;
  logic [3:0]        id_alu_op;
  logic [DATA_W-1:0] id_Rsrc_value;
  logic [DATA_W-1:0] id_Rdst_value;
  logic [REG_AW-1:0] id_Rsrc_address;
  logic [REG_AW-1:0] id_Rdst_address;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic              id_memRead;
  logic              id_memWrite;
  logic              id_WB;
  logic              stall;
  logic              flush;
  logic              memwb_WB;
  logic [REG_AW-1:0] memwb_Rdst_address;
  logic [DATA_W-1:0] memwb_data;

  logic              ex_busy;
  logic [DATA_W-1:0] ALU_result;
  logic [DATA_W-1:0] Rsrc_value;
  logic [DATA_W-1:0] Rdst_value;
  logic [REG_AW-1:0] Rdst_address;
  logic              memRead;
  logic              memWrite;
  logic              WB;
  logic [2:0]        flags;

  modport master (
    output id_valid, id_alu_op, id_Rsrc_value, id_Rdst_value,
           id_Rsrc_address, id_Rdst_address, id_imm, id_use_imm,
           id_memRead, id_memWrite, id_WB, stall, flush,
           memwb_WB, memwb_Rdst_address, memwb_data,
    input  ex_busy, ALU_result, Rsrc_value, Rdst_value, Rdst_address,
           memRead, memWrite, WB, flags
  );

  modport slave (
    input  id_valid, id_alu_op, id_Rsrc_value, id_Rdst_value,
           id_Rsrc_address, id_Rdst_address, id_imm, id_use_imm,
           id_memRead, id_memWrite, id_WB, stall, flush,
           memwb_WB, memwb_Rdst_address, memwb_data,
    output ex_busy, ALU_result, Rsrc_value, Rdst_value, Rdst_address,
           memRead, memWrite, WB, flags
  );

endinterface

// File: rtl/alu_unit.sv
// Combinational ALU: result plus the next CCR value for one operation.
// Opcodes without a defined result (NOP, SETC, CLRC, 14, 15) produce 0.
module alu_unit import pipeline_pkg::*; (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_t           op_i,
  input  logic [2:0]        flags_i,
  output logic [DATA_W-1:0] result_o,
  output logic [2:0]        flags_o
);

  logic [DATA_W:0] wide;
  logic [3:0]      amt;
  logic            updZn;

  // The extra top bit of 'wide' carries carry/borrow; for shifts it catches
  // the last bit pushed out of the word.
  always_comb begin
    result_o = '0;
    flags_o  = flags_i;
    wide     = '0;
    updZn    = 1'b0;
    amt      = b_i[3:0];
    unique case (op_i)
      OP_MOV: result_o = b_i;
      OP_ADD: begin
        wide             = {1'b0, a_i} + {1'b0, b_i};
        result_o         = wide[DATA_W-1:0];
        flags_o[FLAG_C]  = wide[DATA_W];
        updZn            = 1'b1;
      end
      OP_SUB: begin
        wide             = {1'b0, a_i} - {1'b0, b_i};
        result_o         = wide[DATA_W-1:0];
        flags_o[FLAG_C]  = wide[DATA_W];
        updZn            = 1'b1;
      end
      OP_AND: begin
        result_o = a_i & b_i;
        updZn    = 1'b1;
      end
      OP_OR: begin
        result_o = a_i | b_i;
        updZn    = 1'b1;
      end
      OP_NOT: begin
        result_o = ~a_i;
        updZn    = 1'b1;
      end
      OP_INC: begin
        wide             = {1'b0, a_i} + {{DATA_W{1'b0}}, 1'b1};
        result_o         = wide[DATA_W-1:0];
        flags_o[FLAG_C]  = wide[DATA_W];
        updZn            = 1'b1;
      end
      OP_DEC: begin
        wide             = {1'b0, a_i} - {{DATA_W{1'b0}}, 1'b1};
        result_o         = wide[DATA_W-1:0];
        flags_o[FLAG_C]  = wide[DATA_W];
        updZn            = 1'b1;
      end
      OP_SHL: begin
        wide     = {1'b0, a_i} << amt;
        result_o = wide[DATA_W-1:0];
        if (amt != 4'd0) flags_o[FLAG_C] = wide[DATA_W];
        updZn    = 1'b1;
      end
      OP_SHR: begin
        wide     = {a_i, 1'b0} >> amt;
        result_o = wide[DATA_W:1];
        if (amt != 4'd0) flags_o[FLAG_C] = wide[0];
        updZn    = 1'b1;
      end
      OP_SETC: flags_o[FLAG_C] = 1'b1;
      OP_CLRC: flags_o[FLAG_C] = 1'b0;
      OP_MUL: begin
        result_o = a_i * b_i;
        updZn    = 1'b1;
      end
      default: result_o = '0;
    endcase
    if (updZn) begin
      flags_o[FLAG_Z] = (result_o == '0);
      flags_o[FLAG_N] = result_o[DATA_W-1];
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: operand forwarding, ALU, CCR, 2-cycle multiply FSM and
// the EX/MEM buffer. Define EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding.
module execute_stage import pipeline_pkg::*; (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave bus
);

  mul_state_t        state_q, state_d;
  ex_mem_t           exMem_q, exMem_d;
  ex_mem_t           mulHold_q, mulHold_d;
  logic [2:0]        flags_q, flags_d;
  logic              exBusy;

  logic [DATA_W-1:0] fwdRsrc;
  logic [DATA_W-1:0] fwdRdst;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluResult;
  logic [2:0]        aluFlags;
  alu_op_t           op;

`ifdef EX_FORWARD_EN
  // A load sitting in EX/MEM has no data yet, so only MEM/WB may cover it.
  always_comb begin
    fwdRdst = bus.id_Rdst_value;
    if (exMem_q.WB && !exMem_q.memRead && (exMem_q.Rdst_address == bus.id_Rdst_address))
      fwdRdst = exMem_q.ALU_result;
    else if (bus.memwb_WB && (bus.memwb_Rdst_address == bus.id_Rdst_address))
      fwdRdst = bus.memwb_data;

    fwdRsrc = bus.id_Rsrc_value;
    if (exMem_q.WB && !exMem_q.memRead && (exMem_q.Rdst_address == bus.id_Rsrc_address))
      fwdRsrc = exMem_q.ALU_result;
    else if (bus.memwb_WB && (bus.memwb_Rdst_address == bus.id_Rsrc_address))
      fwdRsrc = bus.memwb_data;
  end
`else
  logic unusedFwdInputs;
  assign unusedFwdInputs = ^{bus.memwb_WB, bus.memwb_Rdst_address, bus.memwb_data,
                             bus.id_Rsrc_address};
  assign fwdRdst = bus.id_Rdst_value;
  assign fwdRsrc = bus.id_Rsrc_value;
`endif

  assign opB = bus.id_use_imm ? bus.id_imm : fwdRsrc;
  assign op  = alu_op_t'(bus.id_alu_op);

  alu_unit u_alu (
    .a_i      (fwdRdst),
    .b_i      (opB),
    .op_i     (op),
    .flags_i  (flags_q),
    .result_o (aluResult),
    .flags_o  (aluFlags)
  );

  // Next-state logic: flush beats stall; a MUL spends IDLE emitting a bubble
  // and BUSY emitting the latched product.
  always_comb begin
    state_d   = state_q;
    exMem_d   = exMem_q;
    mulHold_d = mulHold_q;
    flags_d   = flags_q;
    exBusy    = 1'b0;

    if (bus.flush) begin
      exMem_d = '0;
      state_d = MUL_IDLE;
    end else if (bus.stall) begin
      exBusy = (state_q == MUL_BUSY);
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (bus.id_valid) begin
            exMem_d.ALU_result   = aluResult;
            exMem_d.Rsrc_value   = fwdRsrc;
            exMem_d.Rdst_value   = fwdRdst;
            exMem_d.Rdst_address = bus.id_Rdst_address;
            exMem_d.memRead      = bus.id_memRead;
            exMem_d.memWrite     = bus.id_memWrite;
            exMem_d.WB           = bus.id_WB;
            if (op == OP_MUL) begin
              mulHold_d = exMem_d;
              exMem_d   = '0;
              exBusy    = 1'b1;
              state_d   = MUL_BUSY;
            end else begin
              flags_d = aluFlags;
            end
          end else begin
            exMem_d = '0;
          end
        end
        MUL_BUSY: begin
          exMem_d         = mulHold_q;
          flags_d[FLAG_Z] = (mulHold_q.ALU_result == '0);
          flags_d[FLAG_N] = mulHold_q.ALU_result[DATA_W-1];
          state_d         = MUL_IDLE;
        end
        default: state_d = MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MUL_IDLE;
      exMem_q   <= '0;
      mulHold_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      exMem_q   <= exMem_d;
      mulHold_q <= mulHold_d;
      flags_q   <= flags_d;
    end
  end

  assign bus.ex_busy      = exBusy && !rst;
  assign bus.ALU_result   = exMem_q.ALU_result;
  assign bus.Rsrc_value   = exMem_q.Rsrc_value;
  assign bus.Rdst_value   = exMem_q.Rdst_value;
  assign bus.Rdst_address = exMem_q.Rdst_address;
  assign bus.memRead      = exMem_q.memRead;
  assign bus.memWrite     = exMem_q.memWrite;
  assign bus.WB           = exMem_q.WB;
  assign bus.flags        = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed cases then random traffic,
// checked against an arithmetic reference model of the EX stage.
module tb_execute_stage;
  import pipeline_pkg::*;

`ifdef EX_FORWARD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [3:0]  op;
    logic [15:0] rsrcV;
    logic [15:0] rdstV;
    logic [2:0]  rsrcA;
    logic [2:0]  rdstA;
    logic [15:0] imm;
    logic        useImm;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        stall;
    logic        flush;
    logic        mwWb;
    logic [2:0]  mwA;
    logic [15:0] mwD;
  } stim_t;

  typedef struct packed {
    int          idx;
    logic [15:0] res;
    logic [15:0] rsrc;
    logic [15:0] rdst;
    logic [2:0]  addr;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [2:0]  flg;
    logic        resDc;
    logic        valsDc;
  } exp_t;

  logic clk;
  logic rst;
  execute_stage_if bus ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;
  exp_t expQ[$];

  exp_t       mOut;
  exp_t       mMul;
  logic [2:0] mFlags;
  bit         mBusy;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [2:0] adr, input logic [15:0] rf, input stim_t s);
    if (FwdEn && mOut.wb && !mOut.mr && mOut.addr == adr) return mOut.res;
    if (FwdEn && s.mwWb && s.mwA == adr) return s.mwD;
    return rf;
  endfunction

  // Reference ALU: plain integer arithmetic; flags are {C,N,Z}.
  task automatic aluModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] fi, output logic [2:0] fo, output logic [15:0] r);
    longint ua, ub, full;
    int     n;
    logic   c;
    bit     zn;
    ua = longint'(a);
    ub = longint'(b);
    n  = int'(b[3:0]);
    c  = fi[2];
    full = 0;
    zn = 1'b1;
    case (op)
      4'd1:  begin full = ub; zn = 1'b0; end
      4'd2:  begin full = ua + ub; c = (full > 65535); end
      4'd3:  begin full = ua - ub; c = (ua < ub); end
      4'd4:  full = ua & ub;
      4'd5:  full = ua | ub;
      4'd6:  full = 65535 - ua;
      4'd7:  begin full = ua + 1; c = (full > 65535); end
      4'd8:  begin full = ua - 1; c = (ua == 0); end
      4'd9:  begin full = ua << n; if (n != 0) c = ((ua >> (16 - n)) & 1) != 0; end
      4'd10: begin full = ua >> n; if (n != 0) c = ((ua >> (n - 1)) & 1) != 0; end
      4'd11: begin c = 1'b1; zn = 1'b0; end
      4'd12: begin c = 1'b0; zn = 1'b0; end
      4'd13: full = ua * ub;
      default: zn = 1'b0;
    endcase
    full = full & 64'hFFFF;
    r = full[15:0];
    fo = fi;
    fo[2] = c;
    if (zn) begin
      fo[0] = (r == 16'h0000);
      fo[1] = r[15];
    end
  endtask

  task automatic modelStep(input stim_t s, output logic busy);
    logic [15:0] a, b, rs, r;
    logic [2:0]  fo;
    exp_t        n;
    exp_t        bub;
    rs  = fwd(s.rsrcA, s.rsrcV, s);
    a   = fwd(s.rdstA, s.rdstV, s);
    b   = s.useImm ? s.imm : rs;
    bub = '0;
    bub.valsDc = 1'b1;
    busy = 1'b0;
    n = mOut;
    if (s.rst) begin
      n = '0;
      mFlags = 3'b000;
      mBusy = 1'b0;
    end else if (s.flush) begin
      n = bub;
      mBusy = 1'b0;
    end else if (s.stall) begin
      busy = mBusy;
    end else if (mBusy) begin
      n = mMul;
      mFlags[0] = (mMul.res == 16'h0000);
      mFlags[1] = mMul.res[15];
      mBusy = 1'b0;
    end else if (s.valid) begin
      aluModel(s.op, a, b, mFlags, fo, r);
      n = '0;
      n.res = r;
      n.rsrc = rs;
      n.rdst = a;
      n.addr = s.rdstA;
      n.mr = s.mr;
      n.mw = s.mw;
      n.wb = s.wb;
      n.resDc = (s.op == 4'd0) || (s.op == 4'd11) || (s.op == 4'd12) || (s.op >= 4'd14);
      if (s.op == 4'd13) begin
        mMul = n;
        n = bub;
        mBusy = 1'b1;
        busy = 1'b1;
      end else begin
        mFlags = fo;
      end
    end else begin
      n = bub;
    end
    mOut = n;
    n.flg = mFlags;
    n.idx = stepNo;
    stepNo++;
    expQ.push_back(n);
  endtask

  task automatic applyStimulus(input stim_t s);
    logic expBusy;
    @(negedge clk);
    rst                    = s.rst;
    bus.id_valid           = s.valid;
    bus.id_alu_op          = s.op;
    bus.id_Rsrc_value      = s.rsrcV;
    bus.id_Rdst_value      = s.rdstV;
    bus.id_Rsrc_address    = s.rsrcA;
    bus.id_Rdst_address    = s.rdstA;
    bus.id_imm             = s.imm;
    bus.id_use_imm         = s.useImm;
    bus.id_memRead         = s.mr;
    bus.id_memWrite        = s.mw;
    bus.id_WB              = s.wb;
    bus.stall              = s.stall;
    bus.flush              = s.flush;
    bus.memwb_WB           = s.mwWb;
    bus.memwb_Rdst_address = s.mwA;
    bus.memwb_data         = s.mwD;
    modelStep(s, expBusy);
    #1;
    checkOutput($sformatf("ex_busy step %0d", stepNo - 1), 32'(bus.ex_busy), 32'(expBusy));
  endtask

  // Monitor: the EX/MEM buffer is presented every cycle after the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (!e.resDc)
          checkOutput($sformatf("ALU_result step %0d", e.idx), 32'(bus.ALU_result), 32'(e.res));
        if (!e.valsDc) begin
          checkOutput($sformatf("Rsrc_value step %0d", e.idx), 32'(bus.Rsrc_value), 32'(e.rsrc));
          checkOutput($sformatf("Rdst_value step %0d", e.idx), 32'(bus.Rdst_value), 32'(e.rdst));
        end
        checkOutput($sformatf("Rdst_address step %0d", e.idx), 32'(bus.Rdst_address), 32'(e.addr));
        checkOutput($sformatf("memRead step %0d", e.idx), 32'(bus.memRead), 32'(e.mr));
        checkOutput($sformatf("memWrite step %0d", e.idx), 32'(bus.memWrite), 32'(e.mw));
        checkOutput($sformatf("WB step %0d", e.idx), 32'(bus.WB), 32'(e.wb));
        checkOutput($sformatf("flags step %0d", e.idx), 32'(bus.flags), 32'(e.flg));
      end
    end
  end

  function automatic logic [15:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  stim_t s;

  initial begin
    mOut = '0;
    mMul = '0;
    mFlags = 3'b000;
    mBusy = 1'b0;
    s = '0;
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_alu_op = 4'd0; bus.id_Rsrc_value = '0; bus.id_Rdst_value = '0;
    bus.id_Rsrc_address = '0; bus.id_Rdst_address = '0; bus.id_imm = '0; bus.id_use_imm = 1'b0;
    bus.id_memRead = 1'b0; bus.id_memWrite = 1'b0; bus.id_WB = 1'b0; bus.stall = 1'b0;
    bus.flush = 1'b0; bus.memwb_WB = 1'b0; bus.memwb_Rdst_address = '0; bus.memwb_data = '0;

    s = '0; s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // ADD 0x7FFF + 1 -> 0x8000, N=1
    s = '0; s.valid = 1; s.op = 4'd2; s.rdstA = 3; s.rdstV = 16'h7FFF;
    s.imm = 16'h0001; s.useImm = 1; s.wb = 1;
    applyStimulus(s);

    // ADD r1 then SUB reading r1 from EX/MEM
    s = '0; s.valid = 1; s.op = 4'd2; s.rdstA = 1; s.rdstV = 16'd5; s.imm = 16'd2; s.useImm = 1; s.wb = 1;
    applyStimulus(s);
    s = '0; s.valid = 1; s.op = 4'd3; s.rdstA = 1; s.rdstV = 16'd5; s.rsrcA = 2; s.rsrcV = 16'd3; s.wb = 1;
    applyStimulus(s);

    // Load into r1 in EX/MEM, MEM/WB holds 0x0042 for r1
    s = '0; s.valid = 1; s.op = 4'd1; s.rdstA = 1; s.rsrcA = 4; s.rsrcV = 16'h1234; s.mr = 1; s.wb = 1;
    applyStimulus(s);
    s = '0; s.valid = 1; s.op = 4'd3; s.rdstA = 1; s.rdstV = 16'd5; s.rsrcA = 2; s.rsrcV = 16'd3; s.wb = 1;
    s.mwWb = 1; s.mwA = 1; s.mwD = 16'h0042;
    applyStimulus(s);

    // MUL 0x0100 * 0x0100 -> 0x0000, Z=1, after one bubble
    s = '0; s.valid = 1; s.op = 4'd13; s.rdstA = 6; s.rdstV = 16'h0100; s.rsrcA = 5; s.rsrcV = 16'h0100; s.wb = 1;
    applyStimulus(s);
    applyStimulus(s);
    s = '0;
    applyStimulus(s);

    // MUL aborted by flush while BUSY
    s = '0; s.valid = 1; s.op = 4'd13; s.rdstA = 2; s.rdstV = 16'd3; s.rsrcA = 4; s.rsrcV = 16'd5; s.wb = 1;
    applyStimulus(s);
    s.flush = 1;
    applyStimulus(s);

    // Stall held 3 cycles, then stall together with flush
    s = '0; s.valid = 1; s.op = 4'd4; s.rdstA = 7; s.rdstV = 16'hF0F0; s.imm = 16'h0FF0; s.useImm = 1; s.wb = 1;
    applyStimulus(s);
    s.op = 4'd2; s.stall = 1; s.rdstV = 16'hFFFF;
    repeat (3) applyStimulus(s);
    s.flush = 1;
    applyStimulus(s);

    // SHR 3 by 1, INC 0xFFFF, SETC then NOP
    s = '0; s.valid = 1; s.op = 4'd10; s.rdstA = 1; s.rdstV = 16'h0003; s.imm = 16'd1; s.useImm = 1; s.wb = 1;
    applyStimulus(s);
    s = '0; s.valid = 1; s.op = 4'd7; s.rdstA = 5; s.rdstV = 16'hFFFF; s.wb = 1;
    applyStimulus(s);
    s = '0; s.valid = 1; s.op = 4'd12;
    applyStimulus(s);
    s = '0; s.valid = 1; s.op = 4'd11;
    applyStimulus(s);
    s = '0; s.valid = 1; s.op = 4'd0;
    applyStimulus(s);

    // Reset while a MUL is in BUSY
    s = '0; s.valid = 1; s.op = 4'd13; s.rdstA = 3; s.rdstV = 16'h0007; s.rsrcA = 6; s.rsrcV = 16'h0009; s.wb = 1;
    applyStimulus(s);
    s.rst = 1; s.stall = 1;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);

    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.rst    = ($urandom_range(0, 99) == 0);
      s.valid  = ($urandom_range(0, 7) != 0);
      s.op     = 4'($urandom_range(0, 15));
      s.rsrcV  = pickVal();
      s.rdstV  = pickVal();
      s.rsrcA  = 3'($urandom_range(0, 7));
      s.rdstA  = 3'($urandom_range(0, 7));
      s.imm    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 17)) : pickVal();
      s.useImm = 1'($urandom_range(0, 1));
      s.mr     = ($urandom_range(0, 3) == 0);
      s.mw     = ($urandom_range(0, 3) == 0);
      s.wb     = 1'($urandom_range(0, 1));
      if (s.op == 4'd0 || s.op == 4'd11 || s.op == 4'd12 || s.op >= 4'd14) s.wb = 1'b0;
      s.stall  = ($urandom_range(0, 7) == 0);
      s.flush  = ($urandom_range(0, 15) == 0);
      s.mwWb   = 1'($urandom_range(0, 1));
      s.mwA    = 3'($urandom_range(0, 7));
      s.mwD    = pickVal();
      applyStimulus(s);
    end

    s = '0;
    applyStimulus(s);
    @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
